// File: rtl/jzjpcc_writeback_unit.sv
// Writeback stage: selects ALU result or extracted load data, waits for late
// memory data when needed, and drives the register-file write port.
module jzjpcc_writeback_unit #(
  parameter int XLEN     = 32,
  parameter int RETIRE_W = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  rdAddr_in,
  input  logic                        rdWriteEnable_in,
  input  logic                        rdSource_in,
  input  logic [2:0]                  funct3_in,
  input  logic [$clog2(XLEN/8)-1:0]   byteOffset_in,
  input  logic [XLEN-1:0]             aluResult_in,
  input  logic                        memData_valid,
  input  logic [XLEN-1:0]             memData,
  output logic [4:0]                  rdAddr_out,
  output logic [XLEN-1:0]             rd_out,
  output logic                        rdWriteEnable_out,
  output logic                        illegalLoad_out,
  output logic [RETIRE_W-1:0]         retired_out
);

  localparam int OFF_W = $clog2(XLEN/8);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state_q, state_d;
  logic [4:0]        pend_addr;
  logic              pend_we;
  logic [2:0]        pend_f3;
  logic [OFF_W-1:0]  pend_off;

  logic              complete, latch_pend, sel_load, sel_we;
  logic [4:0]        sel_addr;
  logic [2:0]        sel_f3;
  logic [OFF_W-1:0]  sel_off;
  logic [XLEN:0]     load_ext;  // {legal, data}

  // Align the offset to the access size, shift the lane down, then extend.
  function automatic logic [XLEN:0] extract_load(input logic [2:0]       f3,
                                                 input logic [OFF_W-1:0] off,
                                                 input logic [XLEN-1:0]  word);
    logic [OFF_W-1:0] aligned;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  value;
    logic             legal;
    legal   = 1'b1;
    value   = '0;
    aligned = off;
    case (f3)
      3'b001, 3'b101: aligned[0]   = 1'b0;
      3'b010, 3'b110: aligned[1:0] = 2'b00;
      3'b011:         aligned      = '0;
      default:        ;
    endcase
    shifted = word >> {aligned, 3'b000};
    case (f3)
      3'b000: value = XLEN'($signed(shifted[7:0]));
      3'b100: value = XLEN'(shifted[7:0]);
      3'b001: value = XLEN'($signed(shifted[15:0]));
      3'b101: value = XLEN'(shifted[15:0]);
      3'b010: value = XLEN'($signed(shifted[31:0]));
      3'b110: if (XLEN == 64) value = XLEN'(shifted[31:0]); else legal = 1'b0;
      3'b011: if (XLEN == 64) value = shifted;              else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    if (!legal) value = '0;
    return {legal, value};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    complete   = 1'b0;
    latch_pend = 1'b0;
    sel_load   = rdSource_in;
    sel_addr   = rdAddr_in;
    sel_we     = rdWriteEnable_in;
    sel_f3     = funct3_in;
    sel_off    = byteOffset_in;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!rdSource_in || memData_valid) begin
            complete = 1'b1;
          end else begin
            latch_pend = 1'b1;
            state_d    = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        sel_load = 1'b1;
        sel_addr = pend_addr;
        sel_we   = pend_we;
        sel_f3   = pend_f3;
        sel_off  = pend_off;
        if (memData_valid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    load_ext = extract_load(sel_f3, sel_off, memData);
  end

  assign in_ready = (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_addr <= '0;
      pend_we   <= 1'b0;
      pend_f3   <= '0;
      pend_off  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_pend) begin
        pend_addr <= rdAddr_in;
        pend_we   <= rdWriteEnable_in;
        pend_f3   <= funct3_in;
        pend_off  <= byteOffset_in;
      end
    end
  end

  // Strobes drop every cycle; address and data only move on a completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdAddr_out        <= '0;
      rd_out            <= '0;
      rdWriteEnable_out <= 1'b0;
      illegalLoad_out   <= 1'b0;
      retired_out       <= '0;
    end else begin
      rdWriteEnable_out <= 1'b0;
      illegalLoad_out   <= 1'b0;
      if (complete) begin
        rdAddr_out  <= sel_addr;
        retired_out <= retired_out + RETIRE_W'(1);
        if (!sel_load) begin
          rd_out            <= aluResult_in;
          rdWriteEnable_out <= sel_we && (sel_addr != 5'd0);
        end else begin
          rd_out            <= load_ext[XLEN-1:0];
          rdWriteEnable_out <= sel_we && (sel_addr != 5'd0) && load_ext[XLEN];
          illegalLoad_out   <= !load_ext[XLEN];
        end
      end
    end
  end

endmodule
